instr_mem_seq: RTL

//  Parametrised instruction store for the vector core. It is loaded by a host over a

---
 rtl/instr_mem_seq.sv | 98 +++++++++
 1 files changed

// File: rtl/instr_mem_seq.sv
// rtl/instr_mem_seq.sv - instruction store loaded over a beat stream, read by core fetch
// Load and fetch are mutually exclusive by state, so the array never sees read-during-write.
module instr_mem_seq #(
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_start,
  input  logic                     ld_valid,
  input  logic [INSTR_WIDTH-1:0]   ld_data,
  input  logic                     ld_last,
  output logic                     ld_ready,
  output logic                     loaded,
  output logic [$clog2(DEPTH):0]   prog_len,
  input  logic                     fetch_req,
  input  logic [$clog2(DEPTH)-1:0] fetch_addr,
  output logic                     fetch_ready,
  input  logic                     fetch_stall,
  output logic                     fetch_valid,
  output logic [INSTR_WIDTH-1:0]   fetch_data,
  output logic                     fetch_oob
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t                 state;
  logic [AW-1:0]          wr_ptr;
  logic [INSTR_WIDTH-1:0] mem [DEPTH];

  logic ld_fire;
  logic ld_exit;
  logic fetch_fire;
  logic fetch_hold;
  logic in_range;

  assign ld_ready    = (state == LOAD) && !load_start;
  assign ld_fire     = ld_valid && ld_ready;
  assign ld_exit     = ld_last || (wr_ptr == AW'(DEPTH - 1));
  assign fetch_hold  = fetch_valid && fetch_stall;
  assign fetch_ready = (state == RUN) && !load_start && !fetch_hold;
  assign fetch_fire  = fetch_req && fetch_ready;
  // Unsigned AW+1 compare so the top slot stays in range when prog_len == DEPTH.
  assign in_range    = ({1'b0, fetch_addr} < prog_len);

  // Memory contents survive reset; only the write in the reset cycle itself is blocked.
  always_ff @(posedge clk) begin
    if (ld_fire && !rst) begin
      mem[wr_ptr] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      prog_len    <= '0;
      loaded      <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_data  <= '0;
      fetch_oob   <= 1'b0;
    end else begin
      if (load_start) begin
        state    <= LOAD;
        wr_ptr   <= '0;
        prog_len <= '0;
        loaded   <= 1'b0;
      end else if (ld_fire) begin
        if (ld_exit) begin
          state    <= RUN;
          loaded   <= 1'b1;
          prog_len <= {1'b0, wr_ptr} + {{AW{1'b0}}, 1'b1};
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end

      if (load_start) begin
        fetch_valid <= 1'b0;
      end else if (fetch_hold) begin
        fetch_valid <= 1'b1;
      end else if (fetch_fire) begin
        fetch_valid <= 1'b1;
        fetch_oob   <= !in_range;
        fetch_data  <= in_range ? mem[fetch_addr] : '0;
      end else begin
        fetch_valid <= 1'b0;
      end
    end
  end

endmodule
